irq_enc83: RTL and testbench
============================

Name: irq_enc83

Overview:
- 8-source interrupt priority encoder: the encoding counterpart of the 3-to-8 decode used elsewhere in Tom.
- Captures request events into pending latches and applies an enable mask.
- Selects the winning source and presents it as a registered 3-bit vector with a valid/acknowledge handshake to the GPU interrupt logic.
- Sits between the per-unit interrupt sources (video, object processor, timer, blitter, DSP) and the GPU interrupt sequencer.

Parameters:
- EDGE, 1, 1 = pending bits set on rising edge of req; 0 = level mode, pending mirrors registered req.
- PRIO_LOW, 1, 1 = lowest index wins; 0 = highest index wins.

Ports:
- sys_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  8  raw interrupt requests, one bit per source.
- mask  in  8  enable per source; 1 = enabled.
- clr  in  8  software clear of pending bits; 1 = clear.
- ack  in  1  consumer acknowledges the presented index.
- irq_valid  out  1  an index is being presented.
- irq_idx  out  3  presented source index; stable while irq_valid = 1.
- pending  out  8  current pending latches, unmasked.

Behaviour:
- Interface: one clock (sys_clk); reset is synchronous and active-high.
- Reset values:
  - pending = 0x00, irq_valid = 0, irq_idx = 0, state = IDLE.
  - req_prev = 0xFF, so sources already high at reset release do not fire.
- Edge mode (EDGE = 1):
  - Event: ev = req & ~req_prev; req_prev <= req every cycle.
  - Priority for pending[i] each cycle: ev[i] sets (highest), then ack clear of the presented index, then clr[i] clears.
  - A new event on the bit being acked or cleared in the same cycle is never lost.
- Level mode (EDGE = 0): pending <= req each cycle; clr and ack do not alter pending.
- Selection: cand = pending & mask.
  - Winner is the lowest set index (PRIO_LOW = 1) or the highest set index (PRIO_LOW = 0).
  - Winner is computed combinationally from the registered pending/mask; outputs are registered.
- FSM states: IDLE, PRESENT, GAP.
  - IDLE: if cand != 0, latch irq_idx = winner, irq_valid <= 1, go to PRESENT; else stay.
  - PRESENT: irq_idx frozen, even if a higher-priority source becomes pending.
    - ack = 1: pending[irq_idx] cleared (edge mode), irq_valid <= 0, go to GAP.
    - mask[irq_idx] = 0 without ack: withdraw. irq_valid <= 0, go to IDLE, pending untouched.
    - ack and withdraw in the same cycle: ack takes precedence.
  - GAP: exactly one cycle with irq_valid = 0, then behaves as IDLE.
- ack outside PRESENT is ignored.
- Latency:
  - req sampled high at edge E0 → pending bit visible after E0 → irq_valid = 1 after E1 (two clocks).
  - ack at edge A → irq_valid low after A; the next index can be valid after A+1.
- irq_idx holds its last value when irq_valid = 0.
- Reset asserted mid-handshake returns to reset values on the next edge; an outstanding ack is discarded.

Test Plan:
- Edge latency: reset, then mask = 0xFF, req[5] 0→1 at E0 → pending = 0x20 after E0; irq_valid = 1, irq_idx = 5 after E1. ack at E2 → irq_valid = 0, pending = 0x00 after E2, GAP; stays IDLE.
- Priority and frozen index:
  - pending 0x48 with PRIO_LOW = 1 → irq_idx = 3. req[1] rises while presenting → irq_idx stays 3. ack → one GAP cycle, then irq_idx = 1 (pending 0x42), then 6.
  - Repeat with PRIO_LOW = 0 → order 6, 3.
- Mask and withdraw:
  - pending 0x04 with mask 0x00 → irq_valid stays 0.
  - Set mask = 0x04 → valid with idx 2 two cycles later. Drop mask[2] before ack → irq_valid = 0 next cycle, pending still 0x04.
- Simultaneous events:
  - ack on idx 4 in the same cycle as a new req[4] edge → pending[4] remains 1, idx 4 re-presented after GAP.
  - clr = 0x10 with a req[4] edge in the same cycle → pending[4] = 1.
- Reset boundaries:
  - req = 0xFF held through reset release → no pending bits set.
  - Reset asserted while irq_valid = 1 → all outputs at reset values next edge; ack asserted the same cycle has no effect.
- Level mode (EDGE = 0): req = 0x80 held → irq_idx = 7 valid. ack → GAP then re-presents 7. req drops → pending = 0x00 next cycle.

Source files
------------

// File: rtl/irq_enc83.sv
// irq_enc83: 8-source interrupt priority encoder with pending latches,
//   enable mask and a registered valid/ack handshake toward the GPU sequencer.
// Latency: req edge at E0 -> pending after E0 -> irq_valid after E1.
// Backpressure: the presented index is held until ack or until its mask drops.
// Ports:
//   sys_clk, reset (sync, active-high)
//   req[7:0]  raw requests       mask[7:0] per-source enable (1 = enabled)
//   clr[7:0]  software clear     ack       consumer takes irq_idx
//   irq_valid / irq_idx[2:0]     presented source
//   pending[7:0]                 pending latches, before masking
module irq_enc83 #(
  parameter int EDGE     = 1,  // 1 = rising-edge capture, 0 = level mirror
  parameter int PRIO_LOW = 1   // 1 = lowest index wins, 0 = highest wins
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic [7:0] clr,
  input  logic       ack,
  output logic       irq_valid,
  output logic [2:0] irq_idx,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] req_prev_q, req_prev_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic       valid_q, valid_d;
  logic [2:0] idx_q, idx_d;

  logic [7:0] ev;
  logic [7:0] cand;
  logic [7:0] ack_clr;
  logic [2:0] win;

  // Selection works only on registered pending and mask so the winner is
  // a clean function of flop outputs.
  always_comb begin
    cand = pending_q & mask_q;
    win  = 3'd0;
    if (PRIO_LOW != 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (cand[i]) win = i[2:0];
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (cand[i]) win = i[2:0];
      end
    end
  end

  // Handshake FSM. GAP only exists to force one low cycle of irq_valid
  // after an ack; from there it picks the next winner exactly like IDLE.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ack_clr = 8'h00;
    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        valid_d = 1'b0;
        if (cand != 8'h00) begin
          idx_d   = win;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // ack wins over a simultaneous mask withdrawal
        if (ack) begin
          ack_clr[idx_q] = 1'b1;
          valid_d        = 1'b0;
          state_d        = GAP;
        end else if (!mask_q[idx_q]) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Pending update: a fresh event always wins over ack/clr clears so an
  // edge arriving in the same cycle as its own clear is never dropped.
  always_comb begin
    ev         = req & ~req_prev_q;
    req_prev_d = req;
    mask_d     = mask;
    if (EDGE != 0) begin
      pending_d = (pending_q & ~ack_clr & ~clr) | ev;
    end else begin
      pending_d = req;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      // all-ones so sources already high when reset releases do not fire
      req_prev_q <= 8'hFF;
      pending_q  <= 8'h00;
      mask_q     <= 8'h00;
      valid_q    <= 1'b0;
      idx_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_idx   = idx_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_irq_enc83.sv
// tb_irq_enc83: scoreboard bench for irq_enc83 in three configurations
//   (edge/low-prio, edge/high-prio, level/low-prio), each with its own inputs.
// Each driven cycle pushes its expected outputs; they are popped after the edge.
module tb_irq_enc83;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r_req  [3];
  logic [7:0] r_mask [3];
  logic [7:0] r_clr  [3];
  logic       r_ack  [3];
  logic       o_valid[3];
  logic [2:0] o_idx  [3];
  logic [7:0] o_pend [3];

  typedef struct packed {
    logic       v;
    logic [2:0] i;
    logic [7:0] p;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  irq_enc83 #(.EDGE(1), .PRIO_LOW(1)) u_lo (
    .sys_clk(clk), .reset(rst), .req(r_req[0]), .mask(r_mask[0]),
    .clr(r_clr[0]), .ack(r_ack[0]), .irq_valid(o_valid[0]),
    .irq_idx(o_idx[0]), .pending(o_pend[0]));

  irq_enc83 #(.EDGE(1), .PRIO_LOW(0)) u_hi (
    .sys_clk(clk), .reset(rst), .req(r_req[1]), .mask(r_mask[1]),
    .clr(r_clr[1]), .ack(r_ack[1]), .irq_valid(o_valid[1]),
    .irq_idx(o_idx[1]), .pending(o_pend[1]));

  irq_enc83 #(.EDGE(0), .PRIO_LOW(1)) u_lvl (
    .sys_clk(clk), .reset(rst), .req(r_req[2]), .mask(r_mask[2]),
    .clr(r_clr[2]), .ack(r_ack[2]), .irq_valid(o_valid[2]),
    .irq_idx(o_idx[2]), .pending(o_pend[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on DUT d, push what it must show after the next edge,
  // then pop and compare once the edge has happened.
  task automatic cyc(input int d, input logic [7:0] rq, input logic [7:0] mk,
                     input logic [7:0] cl, input logic ak, input logic ev,
                     input logic [2:0] ei, input logic [7:0] ep, input string tag);
    exp_t e;
    r_req[d]  = rq;
    r_mask[d] = mk;
    r_clr[d]  = cl;
    r_ack[d]  = ak;
    sb.push_back('{v: ev, i: ei, p: ep});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".valid"},   {31'd0, o_valid[d]}, {31'd0, e.v});
      check({tag, ".idx"},     {29'd0, o_idx[d]},   {29'd0, e.i});
      check({tag, ".pending"}, {24'd0, o_pend[d]},  {24'd0, e.p});
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      r_req[k] = 8'h00; r_mask[k] = 8'h00; r_clr[k] = 8'h00; r_ack[k] = 1'b0;
    end
    #2;

    // reset values, req held high through reset release
    cyc(0, 8'hFF, 8'h00, 8'h00, 0, 0, 3'd0, 8'h00, "rst");
    rst = 1'b0;
    cyc(0, 8'hFF, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h00, "rel0");
    cyc(0, 8'hFF, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h00, "rel1");
    cyc(0, 8'h00, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h00, "rel2");

    // edge latency on source 5
    cyc(0, 8'h20, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h20, "lat_e0");
    cyc(0, 8'h20, 8'hFF, 8'h00, 0, 1, 3'd5, 8'h20, "lat_e1");
    cyc(0, 8'h20, 8'hFF, 8'h00, 1, 0, 3'd5, 8'h00, "lat_ack");
    cyc(0, 8'h20, 8'hFF, 8'h00, 0, 0, 3'd5, 8'h00, "lat_gap");
    cyc(0, 8'h00, 8'hFF, 8'h00, 0, 0, 3'd5, 8'h00, "lat_idle");

    // low-priority order with frozen index
    cyc(0, 8'h48, 8'hFF, 8'h00, 0, 0, 3'd5, 8'h48, "plo_set");
    cyc(0, 8'h48, 8'hFF, 8'h00, 0, 1, 3'd3, 8'h48, "plo_3");
    cyc(0, 8'h4A, 8'hFF, 8'h00, 0, 1, 3'd3, 8'h4A, "plo_frozen");
    cyc(0, 8'h4A, 8'hFF, 8'h00, 1, 0, 3'd3, 8'h42, "plo_ack3");
    cyc(0, 8'h4A, 8'hFF, 8'h00, 0, 1, 3'd1, 8'h42, "plo_1");
    cyc(0, 8'h4A, 8'hFF, 8'h00, 1, 0, 3'd1, 8'h40, "plo_ack1");
    cyc(0, 8'h4A, 8'hFF, 8'h00, 0, 1, 3'd6, 8'h40, "plo_6");
    cyc(0, 8'h4A, 8'hFF, 8'h00, 1, 0, 3'd6, 8'h00, "plo_ack6");
    cyc(0, 8'h00, 8'hFF, 8'h00, 0, 0, 3'd6, 8'h00, "plo_done");

    // mask gating and withdraw
    cyc(0, 8'h04, 8'h00, 8'h00, 0, 0, 3'd6, 8'h04, "msk_pend");
    cyc(0, 8'h04, 8'h00, 8'h00, 0, 0, 3'd6, 8'h04, "msk_off");
    cyc(0, 8'h04, 8'h04, 8'h00, 0, 0, 3'd6, 8'h04, "msk_on0");
    cyc(0, 8'h04, 8'h04, 8'h00, 0, 1, 3'd2, 8'h04, "msk_on1");
    cyc(0, 8'h04, 8'h00, 8'h00, 0, 1, 3'd2, 8'h04, "wd_drop");
    cyc(0, 8'h04, 8'h00, 8'h00, 0, 0, 3'd2, 8'h04, "wd_low");
    cyc(0, 8'h04, 8'h00, 8'h04, 0, 0, 3'd2, 8'h00, "clr_2");
    cyc(0, 8'h00, 8'hFF, 8'h00, 0, 0, 3'd2, 8'h00, "clr_done");

    // event on the acked bit in the same cycle
    cyc(0, 8'h10, 8'hFF, 8'h00, 0, 0, 3'd2, 8'h10, "sim_set");
    cyc(0, 8'h10, 8'hFF, 8'h00, 0, 1, 3'd4, 8'h10, "sim_4");
    cyc(0, 8'h00, 8'hFF, 8'h00, 0, 1, 3'd4, 8'h10, "sim_fall");
    cyc(0, 8'h10, 8'hFF, 8'h00, 1, 0, 3'd4, 8'h10, "sim_ack_ev");
    cyc(0, 8'h10, 8'hFF, 8'h00, 0, 1, 3'd4, 8'h10, "sim_repres");
    cyc(0, 8'h10, 8'hFF, 8'h00, 1, 0, 3'd4, 8'h00, "sim_ack2");
    cyc(0, 8'h00, 8'hFF, 8'h00, 0, 0, 3'd4, 8'h00, "sim_idle");
    // event on the cleared bit in the same cycle
    cyc(0, 8'h10, 8'hFF, 8'h10, 0, 0, 3'd4, 8'h10, "sim_clr_ev");
    cyc(0, 8'h10, 8'hFF, 8'h00, 0, 1, 3'd4, 8'h10, "sim_clr_pres");

    // high-priority instance: order 6 then 3
    cyc(1, 8'h48, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h48, "phi_set");
    cyc(1, 8'h48, 8'hFF, 8'h00, 0, 1, 3'd6, 8'h48, "phi_6");
    cyc(1, 8'h48, 8'hFF, 8'h00, 1, 0, 3'd6, 8'h08, "phi_ack6");
    cyc(1, 8'h48, 8'hFF, 8'h00, 0, 1, 3'd3, 8'h08, "phi_3");
    cyc(1, 8'h48, 8'hFF, 8'h00, 1, 0, 3'd3, 8'h00, "phi_ack3");

    // level instance: ack and clr leave pending alone
    cyc(2, 8'h80, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h80, "lvl_set");
    cyc(2, 8'h80, 8'hFF, 8'h00, 0, 1, 3'd7, 8'h80, "lvl_7");
    cyc(2, 8'h80, 8'hFF, 8'hFF, 1, 0, 3'd7, 8'h80, "lvl_ack");
    cyc(2, 8'h80, 8'hFF, 8'h00, 0, 1, 3'd7, 8'h80, "lvl_repres");
    cyc(2, 8'h00, 8'hFF, 8'h00, 0, 1, 3'd7, 8'h00, "lvl_drop");
    cyc(2, 8'h00, 8'hFF, 8'h00, 1, 0, 3'd7, 8'h00, "lvl_ack2");
    cyc(2, 8'h00, 8'hFF, 8'h00, 0, 0, 3'd7, 8'h00, "lvl_idle");

    // reset while presenting with ack asserted
    rst = 1'b1;
    cyc(0, 8'h10, 8'hFF, 8'h00, 1, 0, 3'd0, 8'h00, "rst_mid");
    rst = 1'b0;
    cyc(0, 8'h10, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h00, "rst_after");
    cyc(0, 8'h10, 8'hFF, 8'h00, 0, 0, 3'd0, 8'h00, "rst_quiet");

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule
